// File: rtl/aesha_absorb_ctrl.sv
// Absorb sequencer for the AESHA sponge: captures and pads message blocks,
// then steps the state array through one XOR-absorb and NUM_ROUNDS permutation rounds per block.
module aesha_absorb_ctrl #(
  parameter int NUM_ROUNDS = 12,
  parameter int RC_W       = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_blk_valid,
  input  logic [31:0]     i_blk_data [0:3],
  input  logic            i_blk_last,
  input  logic [4:0]      i_blk_nbytes,
  output logic            o_blk_ready,
  output logic [31:0]     o_data [0:3],
  output logic            o_init,
  output logic            o_xor_en,
  output logic            o_round_en,
  output logic [RC_W-1:0] o_round_idx,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PERMUTE,
    S_PADBLK,
    S_DONE
  } state_t;

  localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(NUM_ROUNDS - 1);
  localparam logic [127:0]    PAD_BLOCK  = {8'h80, 112'd0, 8'h01};

  state_t          state_reg, state_next;
  logic [RC_W-1:0] cnt_reg, cnt_next;
  logic            first_reg, first_next;
  logic            last_reg, last_next;
  logic            full_reg, full_next;
  logic            pad_done_reg, pad_done_next;
  logic            rst_done_reg;
  logic [31:0]     data_reg [0:3];
  logic [31:0]     data_next [0:3];

  logic [4:0]      nb_sat;
  logic            pad_en;
  logic [127:0]    cap_flat;

  assign nb_sat = (i_blk_nbytes > 5'd16) ? 5'd16 : i_blk_nbytes;
  assign pad_en = i_blk_last && (nb_sat != 5'd16);

  // Byte k of the captured block sits at cap_flat[8k +: 8]; padding is applied per byte.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam logic [4:0] IDX = 5'(gi);
      logic [7:0] b;
      always_comb begin
        b = i_blk_data[gi / 4][8 * (gi % 4) +: 8];
        if (pad_en) begin
          if (IDX == nb_sat)
            b = 8'h01;
          else if (IDX > nb_sat)
            b = 8'h00;
          if (IDX == 5'd15)
            b = b | 8'h80;
        end
      end
      assign cap_flat[8 * gi +: 8] = b;
    end
  endgenerate

  assign o_blk_ready = (state_reg == S_IDLE) && rst_done_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    first_next    = first_reg;
    last_next     = last_reg;
    full_next     = full_reg;
    pad_done_next = pad_done_reg;
    data_next     = data_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_blk_valid && o_blk_ready) begin
          for (int w = 0; w < 4; w++)
            data_next[w] = cap_flat[32 * w +: 32];
          last_next  = i_blk_last;
          full_next  = i_blk_last && (nb_sat == 5'd16);
          state_next = S_ABSORB;
        end
      end
      S_ABSORB: begin
        first_next = 1'b0;
        cnt_next   = '0;
        state_next = S_PERMUTE;
      end
      S_PERMUTE: begin
        if (cnt_reg == LAST_ROUND) begin
          cnt_next = '0;
          if (last_reg && (!full_reg || pad_done_reg))
            state_next = S_DONE;
          else if (last_reg)
            state_next = S_PADBLK;
          else
            state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_PADBLK: begin
        for (int w = 0; w < 4; w++)
          data_next[w] = PAD_BLOCK[32 * w +: 32];
        pad_done_next = 1'b1;
        state_next    = S_ABSORB;
      end
      S_DONE: begin
        first_next    = 1'b1;
        last_next     = 1'b0;
        full_next     = 1'b0;
        pad_done_next = 1'b0;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // rst_done_reg keeps ready low while reset is held even though the state is already IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      first_reg    <= 1'b1;
      last_reg     <= 1'b0;
      full_reg     <= 1'b0;
      pad_done_reg <= 1'b0;
      rst_done_reg <= 1'b0;
      for (int w = 0; w < 4; w++)
        data_reg[w] <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      first_reg    <= first_next;
      last_reg     <= last_next;
      full_reg     <= full_next;
      pad_done_reg <= pad_done_next;
      rst_done_reg <= 1'b1;
      for (int w = 0; w < 4; w++)
        data_reg[w] <= data_next[w];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
      assign o_data[gi] = data_reg[gi];
    end
  endgenerate

  assign o_init      = (state_reg == S_ABSORB) && first_reg;
  assign o_xor_en    = (state_reg == S_ABSORB);
  assign o_round_en  = (state_reg == S_PERMUTE);
  assign o_round_idx = cnt_reg;
  assign o_busy      = (state_reg != S_IDLE);
  assign o_done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_aesha_absorb_ctrl.sv
// Bench for aesha_absorb_ctrl: table vectors, hand sequences and random blocks checked
// cycle by cycle against a timeline model derived from the block timing rules.
module tb_aesha_absorb_ctrl;

  localparam int N  = 12;
  localparam int IW = 4;
  localparam logic [127:0] PAD = {8'h80, 112'd0, 8'h01};

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_blk_valid;
  logic [31:0]   i_blk_data [0:3];
  logic          i_blk_last;
  logic [4:0]    i_blk_nbytes;
  logic          o_blk_ready;
  logic [31:0]   o_data [0:3];
  logic          o_init;
  logic          o_xor_en;
  logic          o_round_en;
  logic [IW-1:0] o_round_idx;
  logic          o_busy;
  logic          o_done;

  aesha_absorb_ctrl #(.NUM_ROUNDS(N), .RC_W(IW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_blk_valid(i_blk_valid),
    .i_blk_data(i_blk_data), .i_blk_last(i_blk_last), .i_blk_nbytes(i_blk_nbytes),
    .o_blk_ready(o_blk_ready), .o_data(o_data), .o_init(o_init), .o_xor_en(o_xor_en),
    .o_round_en(o_round_en), .o_round_idx(o_round_idx), .o_busy(o_busy), .o_done(o_done)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          ready;
    logic          init;
    logic          xe;
    logic          rnd;
    logic [IW-1:0] idx;
    logic          busy;
    logic          done;
    logic [127:0]  data;
  } obs_t;

  typedef struct {
    logic [127:0] blk;
    logic         last;
    logic [4:0]   nb;
    logic [127:0] exp_data;
    int           exp_done;
  } vec_t;

  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  bit  expect_first = 1'b1;
  int  blk_no = 0;

  always @(negedge i_clk) if (o_done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t s;
    s.ready = o_blk_ready;
    s.init  = o_init;
    s.xe    = o_xor_en;
    s.rnd   = o_round_en;
    s.idx   = o_round_idx;
    s.busy  = o_busy;
    s.done  = o_done;
    s.data  = {o_data[3], o_data[2], o_data[1], o_data[0]};
    return s;
  endfunction

  // Padding rule expressed as masking arithmetic on the whole 128-bit block.
  function automatic logic [127:0] pad_model(logic [127:0] blk, logic last, int nbs);
    logic [127:0] mask;
    if (!last || nbs >= 16) return blk;
    mask = (128'd1 << (8 * nbs)) - 128'd1;
    return (blk & mask) | (128'd1 << (8 * nbs)) | {8'h80, 120'd0};
  endfunction

  // Expected outputs in the j-th cycle after the acceptance edge.
  function automatic obs_t exp_at(int j, bit first, logic [127:0] blk, logic last, int nbs);
    obs_t e;
    bit   full;
    e      = '0;
    full   = last && (nbs >= 16);
    e.data = pad_model(blk, last, nbs);
    if (j == 1) begin
      e.xe = 1'b1; e.init = first; e.busy = 1'b1;
    end else if (j <= N + 1) begin
      e.rnd = 1'b1; e.idx = IW'(j - 2); e.busy = 1'b1;
    end else if (!last) begin
      e.ready = 1'b1;
    end else if (!full) begin
      if (j == N + 2) begin e.done = 1'b1; e.busy = 1'b1; end
      else e.ready = 1'b1;
    end else begin
      if (j >= N + 3) e.data = PAD;
      if (j == N + 2) e.busy = 1'b1;
      else if (j == N + 3) begin e.xe = 1'b1; e.busy = 1'b1; end
      else if (j <= 2 * N + 3) begin e.rnd = 1'b1; e.idx = IW'(j - N - 4); e.busy = 1'b1; end
      else if (j == 2 * N + 4) begin e.done = 1'b1; e.busy = 1'b1; end
      else e.ready = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input logic [127:0] blk, input logic last, input logic [4:0] nb);
    for (int w = 0; w < 4; w++) i_blk_data[w] = blk[32 * w +: 32];
    i_blk_last   = last;
    i_blk_nbytes = nb;
  endtask

  task automatic scramble();
    for (int w = 0; w < 4; w++) i_blk_data[w] = $urandom;
    i_blk_last   = 1'($urandom_range(0, 1));
    i_blk_nbytes = 5'($urandom_range(0, 31));
  endtask

  // Called at a negedge; offers one block, then checks every cycle until ready returns.
  task automatic send_block(input logic [127:0] blk, input logic last, input logic [4:0] nb,
                            input bit hold, input int abort_j,
                            output logic [127:0] first_data, output int done_j, output time acc_t);
    int   nbs, len, waitc, dc0;
    bit   first;
    obs_t got, exp;
    first_data = '0; done_j = -1; acc_t = 0;
    blk_no++;
    drive(blk, last, nb);
    i_blk_valid = 1'b1;
    waitc = 0;
    while (o_blk_ready !== 1'b1) begin
      @(negedge i_clk);
      waitc++;
      if (waitc > 200) begin
        total++; bad++;
        $display("FAIL ready_wait blk=%0d: got ready=%b after %0d cycles, required ready=1", blk_no, o_blk_ready, waitc);
        i_blk_valid = 1'b0;
        return;
      end
    end
    acc_t = $time;
    first = expect_first;
    nbs   = (nb > 5'd16) ? 16 : int'(nb);
    len   = !last ? N + 2 : ((nbs == 16) ? 2 * N + 5 : N + 3);
    done_j = 0;
    @(posedge i_clk);
    for (int j = 1; j <= len; j++) begin
      @(negedge i_clk);
      if (!hold) i_blk_valid = 1'b0;
      got = sample();
      exp = exp_at(j, first, blk, last, nbs);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle blk=%0d j=%0d got=%h required=%h", blk_no, j, got, exp);
      end
      if (j == 1) first_data = got.data;
      if (got.done === 1'b1) done_j = j;
      if (j == abort_j) begin
        dc0 = done_cnt;
        i_rst_n = 1'b0;
        i_blk_valid = 1'b0;
        @(posedge i_clk);
        #1;
        got = sample();
        total++;
        if (got !== obs_t'('0)) begin
          bad++;
          $display("FAIL mid_reset_outputs blk=%0d got=%h required=0", blk_no, got);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        total++;
        if (o_blk_ready !== 1'b1 || o_busy !== 1'b0) begin
          bad++;
          $display("FAIL ready_after_release got ready=%b busy=%b required ready=1 busy=0", o_blk_ready, o_busy);
        end
        total++;
        if (done_cnt != dc0) begin
          bad++;
          $display("FAIL no_done_on_abort got done_count_delta=%0d required 0", done_cnt - dc0);
        end
        expect_first = 1'b1;
        return;
      end
      if (j < len) scramble();
    end
    expect_first = last;
  endtask

  vec_t         vt [6];
  logic [127:0] fd;
  int           dj, dc0;
  time          t1, t2, t3;
  obs_t         g;

  initial begin
    vt[0] = '{128'h11223344_55667788_99AABBCC_DDCCBBAA, 1'b1, 5'd3,
              128'h80000000_00000000_00000000_01CCBBAA, 14};
    vt[1] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, 5'd16,
              128'h0F0E0D0C_0B0A0908_07060504_03020100, 28};
    vt[2] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, 5'd20,
              128'h0F0E0D0C_0B0A0908_07060504_03020100, 28};
    vt[3] = '{{128{1'b1}}, 1'b1, 5'd15,
              128'h81FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 14};
    vt[4] = '{128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0, 5'd5,
              128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0};
    vt[5] = '{128'h55555555_66666666_77777777_88888888, 1'b1, 5'd0,
              128'h80000000_00000000_00000000_00000001, 14};

    i_rst_n = 1'b0;
    i_blk_valid = 1'b0;
    drive('0, 1'b0, 5'd0);
    repeat (3) @(negedge i_clk);
    g = sample();
    total++;
    if (g !== obs_t'('0)) begin
      bad++;
      $display("FAIL reset_state got=%h required=0", g);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    total++;
    if (o_blk_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_reset got ready=%b busy=%b required ready=1 busy=0", o_blk_ready, o_busy);
    end

    for (int i = 0; i < 6; i++) begin
      send_block(vt[i].blk, vt[i].last, vt[i].nb, 1'b0, 0, fd, dj, t1);
      total++;
      if (fd !== vt[i].exp_data) begin
        bad++;
        $display("FAIL vec%0d_data got=%h required=%h", i, fd, vt[i].exp_data);
      end
      total++;
      if (dj != vt[i].exp_done) begin
        bad++;
        $display("FAIL vec%0d_done_cycle got=%0d required=%0d", i, dj, vt[i].exp_done);
      end
      $display("vec %0d last=%b nb=%0d data=%h done_at=%0d", i, vt[i].last, vt[i].nb, fd, dj);
    end

    // Three blocks back to back with valid held high.
    dc0 = done_cnt;
    send_block(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 1'b0, 5'd0, 1'b1, 0, fd, dj, t1);
    send_block(128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, 1'b0, 5'd0, 1'b1, 0, fd, dj, t2);
    send_block(128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF, 1'b1, 5'd7, 1'b0, 0, fd, dj, t3);
    total++;
    if ((t2 - t1) != 140 || (t3 - t2) != 140) begin
      bad++;
      $display("FAIL burst_spacing got=%0t,%0t required=140,140", t2 - t1, t3 - t2);
    end
    total++;
    if (done_cnt - dc0 != 1) begin
      bad++;
      $display("FAIL burst_done_count got=%0d required=1", done_cnt - dc0);
    end
    $display("burst spacing=%0t,%0t dones=%0d", t2 - t1, t3 - t2, done_cnt - dc0);

    // Reset while round index 5 executes, then a fresh message must start with init.
    send_block(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b0, 5'd0, 1'b0, 7, fd, dj, t1);
    send_block(128'h13579BDF_2468ACE0_FDB97531_0ECA8642, 1'b1, 5'd4, 1'b0, 0, fd, dj, t1);
    $display("post-reset block data=%h done_at=%0d", fd, dj);

    for (int i = 0; i < 40; i++) begin
      logic [127:0] rb;
      logic         rl;
      logic [4:0]   rn;
      bit           rh;
      rb = {$urandom, $urandom, $urandom, $urandom};
      rl = (i == 39) ? 1'b1 : ($urandom_range(0, 3) == 0);
      rn = 5'($urandom_range(0, 20));
      rh = (i != 39) && ($urandom_range(0, 1) == 1);
      send_block(rb, rl, rn, rh, 0, fd, dj, t1);
      $display("rand %0d last=%b nb=%0d hold=%b data=%h done_at=%0d", i, rl, rn, rh, fd, dj);
      if (!rh) repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aesha_absorb_ctrl.md
# aesha_absorb_ctrl

Sequencing controller for the AESHA sponge datapath. It accepts 128-bit message blocks over a valid/ready handshake and applies message padding to the final block. It presents each block as the four `i_data` words consumed by the XOR-padding stage, then drives the absorb and permutation-round strobes that step the state array. It signals message completion so the squeeze logic can read the digest.

## Interface
Parameters:
- `NUM_ROUNDS`, 12, permutation rounds per absorbed block (2..15).
- `RC_W`, 4, round-index width; must satisfy NUM_ROUNDS ≤ 2^RC_W.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_blk_valid`  in  1  block offered.
- `i_blk_data`  in  32 x [0:3]  block words; byte k = word k/4, bits [8(k%4)+7 : 8(k%4)].
- `i_blk_last`  in  1  block is final block of message.
- `i_blk_nbytes`  in  5  valid bytes in final block, 0..16; values >16 are treated as 16; ignored when `i_blk_last`=0.
- `o_blk_ready`  out  1  controller can accept a block.
- `o_data`  out  32 x [0:3]  registered, padded block fed to the padding/XOR stage.
- `o_init`  out  1  clear state array this cycle (coincides with first `o_xor_en` of a message).
- `o_xor_en`  out  1  state ← state XOR padded block this cycle.
- `o_round_en`  out  1  execute one permutation round this cycle.
- `o_round_idx`  out  RC_W  index of the round being executed.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse: final permutation complete, digest valid.

## Operation
- FSM states: IDLE, ABSORB, PERMUTE, PADBLK, DONE.
- **IDLE**
  - `o_blk_ready`=1.
  - On `i_blk_valid`&`o_blk_ready`: register the block into `o_data`, latch `last` and `full` (nbytes≥16), then go to ABSORB.
- **Padding of the final block** (applied at capture):
  - When nbytes<16: bytes ≥ nbytes are zeroed, byte nbytes is set to 0x01, and byte 15 is ORed with 0x80. For nbytes=15, byte 15 = 0x81.
  - When nbytes=16: the block is absorbed unpadded and an extra padding block follows.
- **ABSORB** (one cycle)
  - `o_xor_en`=1.
  - `o_init`=1 if the first-block flag is set; the flag is then cleared.
  - Next state is PERMUTE with the round counter at 0.
- **PERMUTE**
  - `o_round_en`=1 and `o_round_idx`=counter. The counter increments each cycle.
  - At counter=NUM_ROUNDS-1 the next state is:
    - DONE if `last` is set and either `full` is clear or the pad block has already been absorbed;
    - PADBLK if `last` and `full` are set and the pad block has not yet been absorbed;
    - IDLE otherwise.
- **PADBLK** (one cycle)
  - `o_data` ← {byte0=0x01, byte15=0x80, all other bytes 0}.
  - Sets the pad-done flag and goes to ABSORB.
- **DONE** (one cycle)
  - `o_done`=1.
  - Sets the first-block flag, clears `last`, `full` and pad-done, and goes to IDLE.
- A final block with nbytes=0 absorbs {byte0=0x01, byte15=0x80}. No extra block follows.
- `o_blk_ready` is 0 outside IDLE. Input changes while not ready are ignored.
- `o_data` holds its value from capture (or PADBLK) until the next capture.

## Timing
- **Reset** (`i_rst_n`=0 at an edge):
  - State goes to IDLE, the first-block flag is set, and the round counter is 0.
  - `o_data` = 0; `o_blk_ready`, `o_init`, `o_xor_en`, `o_round_en`, `o_busy` and `o_done` = 0; `o_round_idx` = 0.
  - `o_blk_ready` rises in the first cycle after reset is released.
  - Reset asserted mid-message aborts the message. No `o_done` is produced, and the next block accepted is treated as a first block.
- **Non-final block** accepted at edge t:
  - `o_xor_en` is high in cycle t+1.
  - Rounds run in cycles t+2 .. t+1+NUM_ROUNDS.
  - `o_blk_ready` is high again in cycle t+2+NUM_ROUNDS.
  - Block-to-block throughput is NUM_ROUNDS+2 cycles.
- **Final block, nbytes<16**: `o_done` in cycle t+2+NUM_ROUNDS; ready in t+3+NUM_ROUNDS.
- **Final block, nbytes=16**:
  - PADBLK in cycle t+2+NUM_ROUNDS and the second `o_xor_en` in t+3+NUM_ROUNDS.
  - `o_done` in t+4+2·NUM_ROUNDS.
- `o_init`, `o_xor_en` and `o_round_en` are mutually exclusive with each other, except that `o_init` always coincides with `o_xor_en`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Single block, short message.** Reset, then a single block with last=1, nbytes=3, data bytes 0xAA,0xBB,0xCC. Required:
  - `o_data` word0=0x01CCBBAA, words 1–2 = 0, word3=0x80000000;
  - `o_init` and `o_xor_en` high together, 12 rounds with idx 0..11, and `o_done` 14 cycles after acceptance.
- **Three blocks, valid held high.** Blocks are accepted every 14 cycles. `o_init` is high only on the first absorb, and exactly one `o_done` is produced after the third block.
- **Full final block** (last=1, nbytes=16). Required:
  - two absorbs, with `o_data` for the second = {0x00000001,0,0,0x80000000};
  - 24 rounds in total and `o_done` at t+28.
- **Empty final block** (last=1, nbytes=0) after one normal block. The padding block is absorbed, with no extra block and no second `o_init`.
- **Reset mid-permutation.** Deassert `i_rst_n` while `o_round_idx`=5. Required:
  - all outputs 0 the next cycle and no `o_done`;
  - the next accepted block raises `o_init`.
- **Ignored and saturated inputs.**
  - Valid asserted during PERMUTE is ignored until ready.
  - nbytes=20 on a final block behaves identically to nbytes=16.
